uart_report_sender: RTL

Transmit-side companion to the UART command decoder. It turns sensor results into fixed-format ASCII report lines and feeds them byte by byte to the UART transmitter.
- DHT11 humidity/temperature and SR04 distance are captured on completion pulses, converted to decimal ASCII and sent in order.
- A start/busy handshake paces the bytes.
- It sits between the sensor controllers and uart_tx, mirroring the rx path (uart_rx -> command decoder).

---
 rtl/uart_report_pkg.sv | 29 ++
 rtl/uart_report_sender_bin_to_bcd.sv | 24 ++
 rtl/uart_report_sender.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_report_pkg.sv
// Shared definitions for the UART report sender: FSM encoding, ASCII bytes
// and fixed message lengths.
package uart_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } state_t;

    localparam logic [7:0] ASC_H     = 8'h48;
    localparam logic [7:0] ASC_T     = 8'h54;
    localparam logic [7:0] ASC_D     = 8'h44;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    localparam int DHT_LEN = 11;
    localparam int SR_LEN  = 7;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return ASC_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/uart_report_sender_bin_to_bcd.sv
// Combinational double-dabble: 9-bit binary to three BCD digits.
module bin_to_bcd (
    input  logic [8:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [20:0] sh;

    always_comb begin
        sh = {12'd0, bin};
        for (int i = 0; i < 9; i++) begin
            if (sh[12:9] >= 4'd5)  sh[12:9]  = sh[12:9]  + 4'd3;
            if (sh[16:13] >= 4'd5) sh[16:13] = sh[16:13] + 4'd3;
            if (sh[20:17] >= 4'd5) sh[20:17] = sh[20:17] + 4'd3;
            sh = {sh[19:0], 1'b0};
        end
        hundreds = sh[20:17];
        tens     = sh[16:13];
        ones     = sh[12:9];
    end

endmodule

// File: rtl/uart_report_sender.sv
// Captures DHT11/SR04 results and streams them to uart_tx as fixed-width
// ASCII report lines ("H:hh T:tt\r\n", "D:ddd\r\n").
module uart_report_sender
    import uart_report_pkg::*;
#(
    parameter int DIST_W  = 9,
    parameter int MAX_DEC = 99
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              report_en,
    input  logic              dht11_done,
    input  logic [7:0]        humidity,
    input  logic [7:0]        temperature,
    input  logic              sr04_done,
    input  logic [DIST_W-1:0] distance,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              sender_busy,
    output logic [2:0]        fsm_state
);

    // Handshake with uart_tx: tx_start is a one-cycle request issued only while
    // tx_busy=0; uart_tx accepts by raising tx_busy, and the byte is finished
    // when tx_busy falls. tx_data is written only in LOAD, so it holds until then.

    state_t state, state_next;

    logic              pend_dht, pend_sr;
    logic [7:0]        buf_h, buf_t;
    logic [DIST_W-1:0] buf_d;

    logic              act_dht;
    logic [7:0]        act_h, act_t;
    logic [DIST_W-1:0] act_d;
    logic [3:0]        idx, last_idx;

    logic dht_trig, sr_trig, take_dht, take_sr;
    logic [7:0] h_clamp, t_clamp, cur_byte;
    logic [3:0] h_hun, h_ten, h_one, t_hun, t_ten, t_one, d_hun, d_ten, d_one;
    logic       unused_hundreds;

    assign dht_trig = report_en & dht11_done;
    assign sr_trig  = report_en & sr04_done;
    assign take_dht = (state == ST_IDLE) & pend_dht;
    assign take_sr  = (state == ST_IDLE) & ~pend_dht & pend_sr;

    assign last_idx    = act_dht ? 4'(DHT_LEN - 1) : 4'(SR_LEN - 1);
    assign sender_busy = (state != ST_IDLE) | pend_dht | pend_sr;
    assign fsm_state   = state;

    // Two-digit fields saturate, so the converter's hundreds digit is always 0.
    assign h_clamp = (act_h > 8'(MAX_DEC)) ? 8'(MAX_DEC) : act_h;
    assign t_clamp = (act_t > 8'(MAX_DEC)) ? 8'(MAX_DEC) : act_t;
    assign unused_hundreds = ^{h_hun, t_hun};

    bin_to_bcd u_bcd_h (.bin({1'b0, h_clamp}), .hundreds(h_hun), .tens(h_ten), .ones(h_one));
    bin_to_bcd u_bcd_t (.bin({1'b0, t_clamp}), .hundreds(t_hun), .tens(t_ten), .ones(t_one));
    bin_to_bcd u_bcd_d (.bin(9'(act_d)),       .hundreds(d_hun), .tens(d_ten), .ones(d_one));

    always_comb begin
        cur_byte = ASC_SPACE;
        if (act_dht) begin
            case (idx)
                4'd0:    cur_byte = ASC_H;
                4'd1:    cur_byte = ASC_COLON;
                4'd2:    cur_byte = bcd_to_ascii(h_ten);
                4'd3:    cur_byte = bcd_to_ascii(h_one);
                4'd4:    cur_byte = ASC_SPACE;
                4'd5:    cur_byte = ASC_T;
                4'd6:    cur_byte = ASC_COLON;
                4'd7:    cur_byte = bcd_to_ascii(t_ten);
                4'd8:    cur_byte = bcd_to_ascii(t_one);
                4'd9:    cur_byte = ASC_CR;
                default: cur_byte = ASC_LF;
            endcase
        end else begin
            case (idx)
                4'd0:    cur_byte = ASC_D;
                4'd1:    cur_byte = ASC_COLON;
                4'd2:    cur_byte = bcd_to_ascii(d_hun);
                4'd3:    cur_byte = bcd_to_ascii(d_ten);
                4'd4:    cur_byte = bcd_to_ascii(d_one);
                4'd5:    cur_byte = ASC_CR;
                default: cur_byte = ASC_LF;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE:    if (pend_dht | pend_sr) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_SEND;
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: if (tx_busy) state_next = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!tx_busy) state_next = (idx == last_idx) ? ST_IDLE : ST_LOAD;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pend_dht <= 1'b0;
            pend_sr  <= 1'b0;
            buf_h    <= '0;
            buf_t    <= '0;
            buf_d    <= '0;
            act_dht  <= 1'b0;
            act_h    <= '0;
            act_t    <= '0;
            act_d    <= '0;
            idx      <= '0;
            tx_data  <= 8'h00;
        end else begin
            state <= state_next;

            // A trigger in the same cycle as the take re-queues the request.
            if (dht_trig) begin
                buf_h    <= humidity;
                buf_t    <= temperature;
                pend_dht <= 1'b1;
            end else if (take_dht) begin
                pend_dht <= 1'b0;
            end

            if (sr_trig) begin
                buf_d   <= distance;
                pend_sr <= 1'b1;
            end else if (take_sr) begin
                pend_sr <= 1'b0;
            end

            if (take_dht) begin
                act_dht <= 1'b1;
                act_h   <= buf_h;
                act_t   <= buf_t;
            end else if (take_sr) begin
                act_dht <= 1'b0;
                act_d   <= buf_d;
            end

            if (state == ST_LOAD) tx_data <= cur_byte;

            if (state == ST_WAIT_LO && !tx_busy)
                idx <= (idx == last_idx) ? 4'd0 : idx + 4'd1;
        end
    end

endmodule
